// File: rtl/mem_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores against an
// internal little-endian word RAM built from four byte lanes. Accesses that
// straddle a word boundary are split over two consecutive RAM cycles.
module mem_access_unit #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  memsizesel,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   word0_q, word0_d;

  // Address bits above the word index never matter: indices wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  logic          is_load, is_store, is_illegal;
  logic [1:0]    off;
  logic [7:0]    size_mask;
  logic [7:0]    lane_mask;
  logic [63:0]   wide_wdata;
  logic          misaligned;
  logic [AW-1:0] word_idx, word_idx_nxt;

  assign is_load    = rd_q & ~wr_q;
  assign is_store   = wr_q & ~rd_q;
  assign is_illegal = rd_q & wr_q;
  assign off        = addr_q[1:0];
  assign word_idx   = addr_q[AW+1:2];
  assign word_idx_nxt = word_idx + AW'(1);

  // Byte-lane mask across the two-word window W, W+1 starting at lane off.
  always_comb begin
    case (size_q)
      2'b01:   size_mask = 8'b0000_0001;
      2'b10:   size_mask = 8'b0000_0011;
      default: size_mask = 8'b0000_1111;
    endcase
  end

  assign lane_mask  = size_mask << off;
  assign wide_wdata = {32'b0, wdata_q} << {off, 3'b000};
  assign misaligned = |lane_mask[7:4];

  // RAM port control. Reads are issued one state early (the accept edge
  // reads W, ACC0 reads W+1) so registered data lines up with the state
  // that consumes it. Reset suppresses any write in flight.
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [7:0]    ram_rbyte [4];

  always_comb begin
    ram_raddr = word_idx;
    ram_waddr = word_idx;
    ram_we    = 4'b0000;
    ram_wdata = wide_wdata[31:0];
    case (state_q)
      IDLE: ram_raddr = addr[AW+1:2];
      ACC0: begin
        ram_raddr = word_idx_nxt;
        if (is_store && !rst) ram_we = lane_mask[3:0];
      end
      ACC1: begin
        ram_waddr = word_idx_nxt;
        ram_wdata = wide_wdata[63:32];
        if (is_store && !rst) ram_we = lane_mask[7:4];
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      // One byte lane: write-enabled store, registered read.
      always_ff @(posedge clk) begin
        if (ram_we[gi]) mem[ram_waddr] <= ram_wdata[8*gi +: 8];
        ram_rbyte[gi] <= mem[ram_raddr];
      end
    end
  endgenerate

  assign ram_rdata = {ram_rbyte[3], ram_rbyte[2], ram_rbyte[1], ram_rbyte[0]};

  // Load assembly: low word is W (held in word0_q when split), high word W+1.
  logic [31:0] lo_word, shifted, load_value;

  always_comb begin
    lo_word = (state_q == ACC1) ? word0_q : ram_rdata;
    shifted = 32'({ram_rdata, lo_word} >> {off, 3'b000});
    case (size_q)
      2'b01:   load_value = uns_q ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      2'b10:   load_value = uns_q ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

  // Next-state logic and request latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    word0_d = word0_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (memread || memwrite)) begin
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          size_d  = memsizesel;
          uns_d   = load_unsigned;
          rd_d    = memread;
          wr_d    = memwrite;
          state_d = ACC0;
        end
      end
      ACC0: begin
        word0_d = ram_rdata;
        if (is_illegal) begin
          state_d = RESP;
        end else if (misaligned) begin
          state_d = ACC1;
        end else begin
          if (is_load) rdata_d = load_value;
          state_d = RESP;
        end
      end
      ACC1: begin
        if (is_load) rdata_d = load_value;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      word0_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      word0_q <= word0_d;
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign err   = (state_q == RESP) & is_illegal;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte-array reference model, directed cases
// for extension, partial/misaligned/wrapping stores, reset and illegal
// requests, then randomized traffic.
module tb_mem_access_unit;

  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        memread;
  logic        memwrite;
  logic [1:0]  memsizesel;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .memread(memread),
    .memwrite(memwrite),
    .memsizesel(memsizesel),
    .load_unsigned(load_unsigned),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .done(done),
    .busy(busy),
    .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem_m [NBYTES];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u);
    int n;
    logic [31:0] v;
    logic [31:0] idx;
    n = size_bytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      idx = (a + 32'(i)) % 32'(NBYTES);
      v[8*i +: 8] = mem_m[idx];
    end
    if (!u) begin
      if (n == 1) v = {{24{v[7]}}, v[7:0]};
      else if (n == 2) v = {{16{v[15]}}, v[15:0]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] idx;
    n = size_bytes(sz);
    for (int i = 0; i < n; i++) begin
      idx = (a + 32'(i)) % 32'(NBYTES);
      mem_m[idx] = d[8*i +: 8];
    end
  endtask

  // One complete request: drive, wait for done (bounded), check latency,
  // busy duration, err, rdata, then the idle bubble while the request is
  // still held, and finally update the model.
  task automatic xact(input logic r, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    int n, exp_lat, lat, bn;
    logic illegal, seen;
    logic [31:0] exp_rd;
    n       = size_bytes(sz);
    illegal = r & w;
    exp_lat = (!illegal && (int'(a[1:0]) + n > 4)) ? 3 : 2;
    exp_rd  = (r && !w) ? model_load(a, sz, u) : last_rdata;

    @(negedge clk);
    req_valid = 1'b1; memread = r; memwrite = w; memsizesel = sz;
    load_unsigned = u; addr = a; wdata = d;

    lat = 0; bn = 0; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    got = rdata;
    if (!seen) begin
      check("done_timeout", 32'(seen), 32'd1);
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(bn), 32'(exp_lat));
      check("err", {31'b0, err}, {31'b0, illegal});
      if (r) check("rdata", rdata, exp_rd);
    end

    @(negedge clk);
    check("bubble_busy", {31'b0, busy}, 32'd0);
    check("no_double_done", {31'b0, done}, 32'd0);
    req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;

    if (w && !r) model_store(a, sz, d);
    if (r && !w) last_rdata = exp_rd;
    $display("xact %s a=0x%08h sz=%0d u=%0b d=0x%08h -> rdata=0x%08h err=%0b lat=%0d",
             illegal ? "ILL" : (w ? "ST " : "LD "), a, sz, u, d, got, err, lat);
  endtask

  logic [31:0] got;
  logic [31:0] exp_v;

  initial begin
    rst = 1'b1; req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    memsizesel = 2'b00; load_unsigned = 1'b0; addr = '0; wdata = '0;
    last_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    rst = 1'b0;

    // Give every RAM word a known random value.
    for (int wi = 0; wi < DEPTH; wi++)
      xact(1'b0, 1'b1, 2'b00, 1'b0, 32'(wi * 4), $urandom, got);

    // Word round trip and extension.
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, got);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, got);
    check("word_roundtrip", got, 32'hDEADBEEF);
    xact(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, got);
    check("byte_signed", got, 32'hFFFFFFDE);
    xact(1'b1, 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, got);
    check("byte_unsigned", got, 32'h000000DE);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, got);
    check("half_signed", got, 32'hFFFFDEAD);
    xact(1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, got);
    check("half_unsigned", got, 32'h0000BEEF);

    // Partial stores.
    xact(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000005A, got);
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h00001234, got);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, got);
    check("partial_store", got, 32'h12345AEF);

    // Misaligned word across 0x20/0x24.
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, got);
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h24, 32'h0, got);
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h11223344, got);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, got);
    check("mis_word_lo", got, 32'h44000000);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h24, 32'h0, got);
    check("mis_word_hi", got, 32'h00112233);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, got);
    check("mis_word_load", got, 32'h11223344);

    // Wrap from word DEPTH-1 into word 0.
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFF, 32'h0000ABCD, got);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFC, 32'h0, got);
    check("wrap_top_byte3", {24'b0, got[31:24]}, 32'h000000CD);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, got);
    check("wrap_bottom_byte0", {24'b0, got[7:0]}, 32'h000000AB);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFF, 32'h0, got);
    check("wrap_half_load", got, 32'hFFFFABCD);

    // Reset in ACC0 of a store: nothing committed, no done.
    exp_v = model_load(32'h40, 2'b00, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; memread = 1'b0; memwrite = 1'b1; memsizesel = 2'b00;
    load_unsigned = 1'b0; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_acc0_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1; req_valid = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    check("rst_busy_low", {31'b0, busy}, 32'd0);
    check("rst_no_done", {31'b0, done}, 32'd0);
    check("rst_rdata_zero", rdata, 32'h0);
    rst = 1'b0;
    last_rdata = 32'h0;
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, got);
    check("rst_no_commit", got, exp_v);

    // Illegal request: err, rdata held, RAM untouched.
    xact(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h12345678, got);
    xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, got);
    check("illegal_no_write", got, exp_v);

    // Randomized traffic, upper address bits randomized too.
    for (int t = 0; t < 300; t++) begin
      int kind;
      logic r, w;
      kind = $urandom_range(0, 9);
      r = (kind == 0) || (kind >= 5);
      w = (kind <= 4);
      xact(r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the pipelined RISC-V machine. It consumes the memory-stage control signals the control unit produces (read/write strobes, access size, load signedness) together with the ALU address and store data. It performs byte, halfword and word loads and stores against an internal little-endian, word-wide synchronous RAM. Misaligned accesses are split into two word accesses, and the unit raises `busy` so the pipeline stalls until `done`.

## Interface
- `DEPTH`, 1024: RAM depth in 32-bit words; power of two; word index = addr[log2(DEPTH)+1:2].
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present; initiator holds all request inputs stable until `done`.
- `memread` in 1: load request.
- `memwrite` in 1: store request.
- `memsizesel` in 2: 00 word, 01 byte, 10 halfword, 11 treated as word.
- `load_unsigned` in 1: funct3[2]; 1 = zero-extend byte/half loads.
- `addr` in 32: byte address.
- `wdata` in 32: store data, low-order bytes used for byte/half.
- `rdata` out 32: registered load result; valid while `done`=1; holds until the next `done`.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high whenever FSM is not IDLE.
- `err` out 1: valid only with `done`; 1 = illegal request.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: when `req_valid` is 1 and (`memread` or `memwrite`) is 1, latch the request and go to ACC0. If neither is set, stay in IDLE. No other state accepts requests.
- Illegal request: `memread` and `memwrite` both 1 -> no RAM access, go to RESP with `err`=1, `rdata` unchanged.
- ACC0: access word W = addr word index.
  - Aligned access (offset + size <= 4): go to RESP.
  - Misaligned access (half at offset 3; word at offset 1, 2 or 3): go to ACC1.
- ACC1: access word (W+1) mod DEPTH, then go to RESP.
- RESP: `done`=1, then go to IDLE. A request still held during RESP is ignored, so one idle bubble occurs before the next accept.
- Stores: little-endian byte-enable writes of exactly the addressed bytes. Bytes outside the access are untouched. Misaligned store bytes are split between W and W+1.
- Loads: assemble bytes little-endian from W (and W+1 if misaligned).
  - Byte/half: sign-extend when `load_unsigned`=0, zero-extend when 1.
  - Word: `load_unsigned` ignored.
- Address wrap: bits above the word index are ignored, so indices wrap modulo DEPTH, including the second word of a misaligned access at index DEPTH-1.
- Reset:
  - state -> IDLE; `rdata`=0, `done`=0, `busy`=0, `err`=0.
  - A write pending in ACC0/ACC1 on the reset edge is not committed; reset beats the write enable.
  - RAM contents are not cleared.

## Timing
- Accept edge E0 moves IDLE->ACC0.
- Aligned access: RESP in the cycle after E1, so `done` is high 2 cycles after E0.
- Misaligned access: `done` is high 3 cycles after E0.
- Illegal request: `done` with `err`=1, 2 cycles after E0.
- RAM has 1-cycle read latency. Word-0 read data for a misaligned load is captured internally before RESP.
- Store data is visible to a load accepted after the store's `done`.
- `busy` is high from the cycle after E0 through RESP inclusive.
- `done` is never high on two consecutive cycles.

## Test plan
- Word round-trip and latency:
  - Stimulus: reset, then store word 0xDEADBEEF at 0x10, then load word at 0x10.
  - Required: load returns `rdata`=0xDEADBEEF with `err`=0; each `done` occurs exactly 2 cycles after its accept edge, and `busy` is high for 2 cycles per request.
- Byte/half extension (memory word 0x10 = 0xDEADBEEF):
  - Byte 0x13 signed -> 0xFFFFFFDE.
  - Byte 0x13 unsigned -> 0x000000DE.
  - Half 0x12 signed -> 0xFFFFDEAD.
  - Half 0x10 unsigned -> 0x0000BEEF.
- Partial store: store byte 0x5A at 0x11, then store half 0x1234 at 0x12; word load at 0x10 -> 0x12345AEF.
- Misaligned word at 0x23 (words 0x20 and 0x24 pre-zeroed):
  - Store 0x11223344 at 0x23 -> word 0x20 = 0x44000000, word 0x24 = 0x00112233.
  - Word load at 0x23 -> 0x11223344, `done` 3 cycles after accept.
- Wrap: with DEPTH=1024, store half 0xABCD at 0xFFF -> word 1023 byte 3 = 0xCD, word 0 byte 0 = 0xAB; half load at 0xFFF -> 0xFFFFABCD.
- Reset and illegal request:
  - Assert `rst` during ACC0 of a word store of 0xCAFEF00D to 0x40 -> word 0x40 unchanged, no `done`, `busy`=0 next cycle.
  - Request with `memread`=`memwrite`=1 -> `done`+`err` after 2 cycles, RAM unchanged.
